xswitch_ingress_queue: RTL
==========================

// Module: xswitch_ingress_queue
// PURPOSE
//  Per-port ingress buffer directly upstream of one xswitch input port (one instance per port).
//  Accepts (data, addr) items from a source, queues them, and presents them on the switch's
//  data_in/addr_in/valid_in inputs, honouring the switch's rcv_rdy.
//  Rejects out-of-range addresses; flags a port held off by the switch too long.
// PARAMETERS
//  DATA_W     8    data width, matches xswitch data_in lane
//  ADDR_W     4    addr width, matches xswitch addr_in lane (binary port number)
//  NUM_PORTS  4    legal destinations are 0..NUM_PORTS-1
//  DEPTH      8    storage entries, power of 2, >=2
//  STALL_MAX  64   cycles valid_in may wait unaccepted before stall asserts
// PORTS
//  clk        in   1            switch clock
//  reset      in   1            asynchronous, active-high
//  src_valid  in   1            source offers an item
//  src_data   in   DATA_W       source data
//  src_addr   in   ADDR_W       source destination port
//  src_ready  out  1            queue can take an item this cycle
//  valid_in   out  1            item presented to xswitch
//  data_in    out  DATA_W       presented data
//  addr_in    out  ADDR_W       presented destination
//  rcv_rdy    in   1            xswitch accepts the presented item
//  count      out  $clog2(DEPTH+2)  items held (storage + output register)
//  drop_cnt   out  16           items discarded, saturating at 16'hFFFF
//  stall      out  1            presented item waited >= STALL_MAX cycles
// BEHAVIOUR
//  - Reset (async assert, sync-release use): all outputs 0, queue empty, FSM=EMPTY, stall timer 0.
//  - Push: src_valid & src_ready at posedge. src_ready = (storage not full), combinational from regs.
//  - Push with src_addr >= NUM_PORTS: accepted (src_ready honoured) but discarded; drop_cnt+1.
//  - src_valid while src_ready=0: item lost, drop_cnt+1. A same-cycle pop does NOT free space for it.
//  - Pop: valid_in & rcv_rdy at posedge. data_in/addr_in stable while valid_in=1 and unaccepted.
//  - Output register refilled from storage on pop or when empty; push into fully empty queue
//    appears on valid_in the next cycle (1-cycle latency, bypass into output reg).
//  - Back-to-back: with rcv_rdy=1 continuously, one item per cycle, no bubbles.
//  - Simultaneous push+pop (not full): both happen, count unchanged.
//  - FSM: EMPTY (valid_in=0) -> PRESENT on load; PRESENT -> EMPTY on pop with nothing to refill;
//    PRESENT -> STALLED when wait timer reaches STALL_MAX; STALLED -> PRESENT/EMPTY on pop.
//    stall=1 only in STALLED. Timer clears on every pop; counts only while valid_in & !rcv_rdy.
//  - Pointers wrap modulo DEPTH; count never exceeds DEPTH+1; drop_cnt saturates, never wraps.
//  - Reset mid-transfer: presented item and all stored items discarded, drop_cnt cleared.
// STRUCTURE
//  - xswitch_pkg: DATA_W, ADDR_W, NUM_PORTS constants; typedef struct {data, addr} xsw_item_t;
//    typedef enum {EMPTY, PRESENT, STALLED} iq_state_t.
//  - Sub-module xsw_sync_fifo (DEPTH x xsw_item_t, full/empty/level); this block adds output
//    register, address check, FSM, stall timer, drop counter.
// TESTING
//  1 Reset: assert reset mid-queue (5 items) -> all outputs 0, count=0 immediately (async).
//  2 Single item data=8'hA5 addr=2 into empty, rcv_rdy=1 -> valid_in next cycle, accepted, count 0.
//  3 rcv_rdy=0, push 9 items -> src_ready=0 after 9th (DEPTH+1 held); 10th push -> drop_cnt=1.
//  4 Stream 20 items, rcv_rdy=1 -> 20 consecutive valid_in cycles, order and values preserved.
//  5 Push addr=4'd7 -> never on valid_in, drop_cnt increments by 1.
//  6 Hold rcv_rdy=0 64 cycles with item presented -> stall=1 at cycle 64; rcv_rdy=1 -> stall=0.

Source files
------------

// File: rtl/xswitch_pkg.sv
// rtl/xswitch_pkg.sv - shared widths, item type and ingress FSM states for xswitch ports
package xswitch_pkg;

    localparam int DATA_W    = 8;
    localparam int ADDR_W    = 4;
    localparam int NUM_PORTS = 4;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] addr;
    } xsw_item_t;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PRESENT = 2'd1,
        STALLED = 2'd2
    } iq_state_t;

endpackage

// File: rtl/xsw_sync_fifo.sv
// rtl/xsw_sync_fifo.sv - single-clock first-word-fallthrough item fifo with level
module xsw_sync_fifo
    import xswitch_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_wr_en,
    input  xsw_item_t                  i_wr_item,
    input  logic                       i_rd_en,
    output xsw_item_t                  o_rd_item,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH+1)-1:0] o_level
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    xsw_item_t   r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;

    logic w_wr;
    logic w_rd;

    // Head entry is visible without a read strobe; pointers wrap because DEPTH is a power of 2.
    assign o_full    = (r_level == LW'(DEPTH));
    assign o_empty   = (r_level == '0);
    assign o_level   = r_level;
    assign o_rd_item = r_mem[r_rd_ptr];
    assign w_wr      = i_wr_en && !o_full;
    assign w_rd      = i_rd_en && !o_empty;

    // Storage array carries no reset; stale entries are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_wr_item;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_wr, w_rd})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/xswitch_ingress_queue.sv
// rtl/xswitch_ingress_queue.sv - per-port ingress buffer feeding one xswitch input
module xswitch_ingress_queue
    import xswitch_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int STALL_MAX = 64
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        src_valid,
    input  logic [DATA_W-1:0]           src_data,
    input  logic [ADDR_W-1:0]           src_addr,
    output logic                        src_ready,
    output logic                        valid_in,
    output logic [DATA_W-1:0]           data_in,
    output logic [ADDR_W-1:0]           addr_in,
    input  logic                        rcv_rdy,
    output logic [$clog2(DEPTH+2)-1:0]  count,
    output logic [15:0]                 drop_cnt,
    output logic                        stall
);

    localparam int CW = $clog2(DEPTH+2);
    localparam int LW = $clog2(DEPTH+1);
    localparam int TW = $clog2(STALL_MAX+1);
    localparam logic [ADDR_W:0] PORT_LIMIT = (ADDR_W+1)'(NUM_PORTS);

    iq_state_t     r_state;
    iq_state_t     w_next_state;
    xsw_item_t     r_item;
    logic [TW-1:0] r_timer;
    logic [15:0]   r_drop_cnt;

    xsw_item_t     w_fifo_item;
    logic          w_fifo_full;
    logic          w_fifo_empty;
    logic [LW-1:0] w_fifo_level;

    logic w_valid;
    logic w_addr_ok;
    logic w_accept;
    logic w_good;
    logic w_pop;
    logic w_load;
    logic w_fifo_rd;
    logic w_bypass;
    logic w_fifo_wr;
    logic w_drop;
    logic w_refill;

    // Output register empties first, so it is refilled from storage before a new push can bypass.
    assign w_valid   = (r_state != EMPTY);
    assign w_addr_ok = ({1'b0, src_addr} < PORT_LIMIT);
    assign w_accept  = src_valid && src_ready;
    assign w_good    = w_accept && w_addr_ok;
    assign w_pop     = w_valid && rcv_rdy;
    assign w_load    = !w_valid || w_pop;
    assign w_fifo_rd = w_load && !w_fifo_empty;
    assign w_bypass  = w_load && w_fifo_empty && w_good;
    assign w_fifo_wr = w_good && !w_bypass;
    assign w_refill  = w_fifo_rd || w_bypass;
    assign w_drop    = src_valid && (!src_ready || !w_addr_ok);

    // Ready masked during reset so every output reads 0 while it is held.
    assign src_ready = !w_fifo_full && !reset;
    assign valid_in  = w_valid;
    assign data_in   = r_item.data;
    assign addr_in   = r_item.addr;
    assign count     = CW'(w_fifo_level) + CW'(w_valid);
    assign drop_cnt  = r_drop_cnt;
    assign stall     = (r_state == STALLED);

    xsw_sync_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (reset),
        .i_wr_en   (w_fifo_wr),
        .i_wr_item (xsw_item_t'{data: src_data, addr: src_addr}),
        .i_rd_en   (w_fifo_rd),
        .o_rd_item (w_fifo_item),
        .o_full    (w_fifo_full),
        .o_empty   (w_fifo_empty),
        .o_level   (w_fifo_level)
    );

    // Presentation state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next presentation state: load, pop, and hold-off escalation to STALLED.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            EMPTY: begin
                if (w_refill) begin
                    w_next_state = PRESENT;
                end
            end
            PRESENT: begin
                if (w_pop) begin
                    w_next_state = w_refill ? PRESENT : EMPTY;
                end else if (r_timer >= TW'(STALL_MAX - 1)) begin
                    w_next_state = STALLED;
                end
            end
            STALLED: begin
                if (w_pop) begin
                    w_next_state = w_refill ? PRESENT : EMPTY;
                end
            end
            default: w_next_state = EMPTY;
        endcase
    end

    // Output register: storage head has priority, otherwise the incoming item bypasses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_item <= '0;
        end else if (w_fifo_rd) begin
            r_item <= w_fifo_item;
        end else if (w_bypass) begin
            r_item <= xsw_item_t'{data: src_data, addr: src_addr};
        end
    end

    // Hold-off timer: counts cycles the presented item is refused, saturates at STALL_MAX.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_timer <= '0;
        end else if (w_pop || !w_valid) begin
            r_timer <= '0;
        end else if (!rcv_rdy && (r_timer != TW'(STALL_MAX))) begin
            r_timer <= r_timer + TW'(1);
        end
    end

    // Discard counter for refused or misaddressed items, saturating rather than wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
            r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

endmodule
